mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's gate-level 4:1 single-bit mux between four requesters. It grants one requester at a time for a fixed burst of cycles and drives the mux select from its registered grant. It forwards the selected data bit as `ans`, qualified by `valid`. It sits in front of the mux as its only driver of `sel`.

---
 rtl/mux_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared gate-level 4:1 mux and grants fixed BURST-cycle slots.
// Defining MUX_ARB_LOCK_EN adds the i_lock port, which lets an owner extend its grant by another burst.
module mux4_gate (
    input  logic [3:0] i_d,
    input  logic [1:0] i_s,
    output logic       o_y
);
    logic [1:0] w_sn;
    logic [3:0] w_term;

    assign w_sn      = ~i_s;
    assign w_term[0] = i_d[0] & w_sn[1] & w_sn[0];
    assign w_term[1] = i_d[1] & w_sn[1] & i_s[0];
    assign w_term[2] = i_d[2] & i_s[1]  & w_sn[0];
    assign w_term[3] = i_d[3] & i_s[1]  & i_s[0];
    assign o_y       = w_term[0] | w_term[1] | w_term[2] | w_term[3];
endmodule

module mux_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic [3:0] i_in,
`ifdef MUX_ARB_LOCK_EN
    input  logic [3:0] i_lock,
`endif
    output logic [1:0] o_sel,
    output logic [3:0] o_grant,
    output logic       o_valid,
    output logic       o_ans,
    output logic       o_done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] LAST = 4'(BURST - 1);

    logic [0:0] r_state;
    logic [1:0] r_sel;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic [3:0] r_cnt;

    logic       w_busy;
    logic       w_owner_req;
    logic       w_last;
    logic       w_done;
    logic       w_hold;
    logic       w_arb;
    logic [2:0] w_pick;
    logic       w_mux_y;

    // Returns {found, index}; the lowest rotation offset from i_ptr wins.
    function automatic logic [2:0] f_pick(input logic [3:0] i_r, input logic [1:0] i_ptr);
        logic [1:0] idx;
        f_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = i_ptr + 2'(k);
            if (i_r[idx]) begin
                f_pick = {1'b1, idx};
            end
        end
    endfunction

    assign w_busy      = (r_state == BUSY);
    assign w_owner_req = i_req[r_sel];
    assign w_last      = (r_cnt == LAST);
    assign w_done      = w_busy & (w_last | ~w_owner_req);
    assign w_arb       = ~w_busy | w_done;
    assign w_pick      = f_pick(i_req, r_ptr);

`ifdef MUX_ARB_LOCK_EN
    // Only a full-length burst with the owner still requesting may be extended.
    assign w_hold = w_done & w_last & w_owner_req & i_lock[r_sel];
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_grant <= 4'b0000;
            r_cnt   <= 4'd0;
        end else if (w_hold) begin
            r_cnt <= 4'd0;
        end else if (w_arb) begin
            if (w_pick[2]) begin
                r_state <= BUSY;
                r_sel   <= w_pick[1:0];
                r_grant <= 4'b0001 << w_pick[1:0];
                r_cnt   <= 4'd0;
                r_ptr   <= w_pick[1:0] + 2'd1;
            end else if (w_busy) begin
                r_state <= IDLE;
                r_grant <= 4'b0000;
            end
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    mux4_gate u_mux (
        .i_d (i_in),
        .i_s (r_sel),
        .o_y (w_mux_y)
    );

    assign o_sel   = r_sel;
    assign o_grant = r_grant;
    assign o_valid = w_busy & w_owner_req;
    assign o_ans   = w_mux_y & o_valid;
    assign o_done  = w_done;

    a_grant_onehot_sel: assert property (@(posedge i_clk) disable iff (i_rst)
        r_grant == (w_busy ? (4'b0001 << r_sel) : 4'b0000));
    a_cnt_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
        !w_busy || (r_cnt <= LAST));
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: per-cycle comparison against a behavioural owner/turn model plus literal checks.
module tb_mux_rr_arbiter;
    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] lock;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       ans;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.BURST(BURST)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_in    (in),
`ifdef MUX_ARB_LOCK_EN
        .i_lock  (lock),
`endif
        .o_sel   (sel),
        .o_grant (grant),
        .o_valid (valid),
        .o_ans   (ans),
        .o_done  (done)
    );

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the mux, how many cycles it has used, whose turn is first.
    int m_owner = -1;
    int m_sel   = 0;
    int m_first = 0;
    int m_used  = 0;

    function automatic int first_requester(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic model_done();
        if (m_owner < 0) return 1'b0;
        return (m_used == BURST - 1) || !req[m_owner];
    endfunction

    always @(posedge clk) begin
        int w;
        logic finishing;
        finishing = model_done();
        if (rst) begin
            m_owner = -1; m_sel = 0; m_first = 0; m_used = 0;
        end else if (m_owner >= 0 && !finishing) begin
            m_used = m_used + 1;
`ifdef MUX_ARB_LOCK_EN
        end else if (m_owner >= 0 && m_used == BURST - 1 && req[m_owner] && lock[m_owner]) begin
            m_used = 0;
`endif
        end else begin
            w = first_requester(req, m_first);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_used = 0; m_first = (w + 1) % 4;
            end else begin
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        logic       ev;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        ev = (m_owner >= 0) && req[m_owner];
        chk("model_grant", grant, eg);
        chk("model_sel", {2'b00, sel}, 4'(m_sel));
        chk("model_valid", {3'b000, valid}, {3'b000, ev});
        chk("model_ans", {3'b000, ans}, {3'b000, ev && in[m_sel]});
        chk("model_done", {3'b000, done}, {3'b000, model_done()});
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1; req = 4'b0000; lock = 4'b0000;
        next();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        rst = 1'b1; req = 4'b1111; in = 4'b0000; lock = 4'b0000;

        // Reset with everyone requesting, then full contention rotation.
        next();
        @(negedge clk);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_sel", {2'b00, sel}, 4'b0000);
        chk("rst_valid", {3'b000, valid}, 4'b0000);
        chk("rst_ans", {3'b000, ans}, 4'b0000);
        next();
        rst = 1'b0;
        next();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            eg = 4'b0001 << ((i / 4) % 4);
            chk("rr_grant", grant, eg);
            chk("rr_valid", {3'b000, valid}, 4'b0001);
            chk("rr_done", {3'b000, done}, {3'b000, (i % 4) == 3});
            next();
        end

        // Single requester re-granted with no gap.
        restart();
        req = 4'b0100; in = 4'b0100;
        next();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("single_grant", grant, 4'b0100);
            chk("single_sel", {2'b00, sel}, 4'd2);
            chk("single_ans", {3'b000, ans}, 4'b0001);
            chk("single_done", {3'b000, done}, {3'b000, (i % 4) == 3});
            next();
        end

        // Early release by owner 1 hands over to requester 2.
        restart();
        req = 4'b0110; in = 4'b0010;
        next();
        @(negedge clk);
        chk("early_grant0", grant, 4'b0010);
        chk("early_ans0", {3'b000, ans}, 4'b0001);
        chk("early_done0", {3'b000, done}, 4'b0000);
        next();
        req = 4'b0100;
        @(negedge clk);
        chk("early_valid1", {3'b000, valid}, 4'b0000);
        chk("early_ans1", {3'b000, ans}, 4'b0000);
        chk("early_done1", {3'b000, done}, 4'b0001);
        next();
        @(negedge clk);
        chk("early_next_grant", grant, 4'b0100);
        chk("early_next_sel", {2'b00, sel}, 4'd2);
        next();

        // Owner 3 finishes; pointer wraps to requester 0.
        restart();
        req = 4'b1000;
        next();
        @(negedge clk);
        chk("wrap_grant0", grant, 4'b1000);
        next();
        req = 4'b1001;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_grant", grant, 4'b1000);
            chk("wrap_done", {3'b000, done}, {3'b000, i == 3});
            next();
        end
        @(negedge clk);
        chk("wrap_next_grant", grant, 4'b0001);
        chk("wrap_next_sel", {2'b00, sel}, 4'd0);
        next();

`ifdef MUX_ARB_LOCK_EN
        // Lock holds owner 0 for a second burst, then rotation resumes.
        restart();
        req = 4'b0011; lock = 4'b0001;
        next();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lock_grant", grant, 4'b0001);
            chk("lock_done", {3'b000, done}, {3'b000, (i % 4) == 3});
            next();
            if (i == 4) lock = 4'b0000;
        end
        @(negedge clk);
        chk("lock_next_grant", grant, 4'b0010);
        next();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
